// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Brief    : IF-stage front end. Owns the PC, fetches over a req/ack memory
//             handshake and steers the IF/ID register with bubbles and holds.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int                     ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard_freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_addr,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [ADDRESS_LEN-1:0] imem_rdata,
    output logic [ADDRESS_LEN-1:0] PC_out,
    output logic [ADDRESS_LEN-1:0] Instruction_out,
    output logic                   ifid_freeze,
    output logic                   ifid_flush
);

    localparam logic [ADDRESS_LEN-1:0] c_PC_STEP    = ADDRESS_LEN'(4);
    localparam logic [ADDRESS_LEN-1:0] c_ALIGN_MASK = ~ADDRESS_LEN'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDRESS_LEN-1:0] r_pc;
    logic [ADDRESS_LEN-1:0] w_pc_nxt;
    logic [ADDRESS_LEN-1:0] r_instr_buf;
    logic [ADDRESS_LEN-1:0] w_instr_buf_nxt;
    logic [ADDRESS_LEN-1:0] r_pc_out;
    logic [ADDRESS_LEN-1:0] w_pc_out_nxt;
    logic [ADDRESS_LEN-1:0] r_req_addr;
    logic [ADDRESS_LEN-1:0] w_req_addr_nxt;

    logic [ADDRESS_LEN-1:0] w_pc_plus4;
    logic [ADDRESS_LEN-1:0] w_branch_target;

    assign w_pc_plus4      = r_pc + c_PC_STEP;
    assign w_branch_target = branch_addr & c_ALIGN_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr_buf <= '0;
            r_pc_out    <= '0;
            r_req_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr_buf <= w_instr_buf_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_req_addr  <= w_req_addr_nxt;
        end
    end

    // r_req_addr latches the issued address so a squashed request in DRAIN
    // keeps presenting it while pc already points at the branch target.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_buf_nxt = r_instr_buf;
        w_pc_out_nxt    = r_pc_out;
        w_req_addr_nxt  = r_req_addr;
        imem_req        = 1'b0;
        ifid_flush      = 1'b1;
        ifid_freeze     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req       = 1'b1;
                w_req_addr_nxt = r_pc;
                if (branch_taken) begin
                    w_pc_nxt    = w_branch_target;
                    w_state_nxt = imem_ack ? S_REQ : S_DRAIN;
                end else if (imem_ack) begin
                    w_instr_buf_nxt = imem_rdata;
                    w_pc_out_nxt    = w_pc_plus4;
                    w_state_nxt     = S_VALID;
                end
            end
            S_VALID: begin
                ifid_flush  = branch_taken;
                ifid_freeze = hazard_freeze & ~branch_taken;
                if (branch_taken) begin
                    w_pc_nxt    = w_branch_target;
                    w_state_nxt = S_REQ;
                end else if (!hazard_freeze) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    w_pc_nxt = w_branch_target;
                end
                if (imem_ack) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_addr       = (r_state == S_REQ) ? r_pc : r_req_addr;
    assign PC_out          = r_pc_out;
    assign Instruction_out = r_instr_buf;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_unit
//  Brief    : Randomized bench for if_fetch_unit against a transaction-level
//             model of program order, memory latency and IF/ID hand-off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_RST_PC = 32'hFFFF_FFFC;

    logic        clk           = 1'b0;
    logic        rst           = 1'b1;
    logic        hazard_freeze = 1'b0;
    logic        branch_taken  = 1'b0;
    logic [31:0] branch_addr   = '0;
    logic        imem_ack      = 1'b0;
    logic [31:0] imem_rdata    = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        ifid_freeze;
    logic        ifid_flush;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc;
    logic        pending;
    logic        live;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [31:0] last_pc_out;
    logic [31:0] last_instr;
    int          req_cnt;
    int          req_lat;
    int          accepted;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDRESS_LEN (32),
        .RESET_PC    (c_RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_freeze   (hazard_freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .Instruction_out (Instruction_out),
        .ifid_freeze     (ifid_freeze),
        .ifid_flush      (ifid_flush)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A1E};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_init();
        exp_pc      = c_RST_PC;
        pending     = 1'b0;
        live        = 1'b0;
        prev_req    = 1'b0;
        prev_ack    = 1'b0;
        prev_addr   = '0;
        last_pc_out = '0;
        last_instr  = '0;
        req_cnt     = 0;
        req_lat     = 1;
    endtask

    task automatic quiet_inputs();
        hazard_freeze = 1'b0;
        branch_taken  = 1'b0;
        imem_ack      = 1'b0;
        branch_addr   = '0;
        imem_rdata    = '0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"},   imem_req,        0);
        chk({tag, "_addr"},  imem_addr,       0);
        chk({tag, "_pcout"}, PC_out,          0);
        chk({tag, "_instr"}, Instruction_out, 0);
        chk({tag, "_flush"}, ifid_flush,      1);
        chk({tag, "_frz"},   ifid_freeze,     0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        quiet_inputs();
        rst = 1'b1;
        #1;
        chk("idle_req",   imem_req,   0);
        chk("idle_flush", ifid_flush, 1);
        model_init();
    endtask

    // One clock cycle: drive memory/hazard/branch, then score against the model.
    task automatic step(input int br_pct, input int hz_pct);
        logic        new_req;
        logic        in_flight;
        logic [31:0] tgt;
        @(negedge clk);
        in_flight = prev_req && !prev_ack;
        new_req   = imem_req && !in_flight;
        if (new_req) begin
            req_cnt = 0;
            req_lat = $urandom_range(1, 4);
        end
        if (imem_req) begin
            req_cnt++;
            imem_ack   = (req_cnt >= req_lat);
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        end else begin
            imem_ack   = ($urandom_range(0, 9) == 0);
            imem_rdata = $urandom;
        end
        branch_taken  = ($urandom_range(0, 99) < br_pct);
        branch_addr   = $urandom;
        hazard_freeze = ($urandom_range(0, 99) < hz_pct);
        tgt           = branch_addr & 32'hFFFF_FFFC;
        #1;

        chk("req_level", imem_req, !pending);
        if (in_flight) begin
            chk("req_hold",  imem_req,  1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        if (new_req) begin
            chk("req_addr", imem_addr, exp_pc);
            live = 1'b1;
        end
        if (pending) begin
            chk("flush",  ifid_flush,      branch_taken);
            chk("freeze", ifid_freeze,     hazard_freeze & ~branch_taken);
            chk("pc_out", PC_out,          exp_pc + 32'd4);
            chk("instr",  Instruction_out, mem_word(exp_pc));
        end else begin
            chk("bubble_flush",  ifid_flush,      1);
            chk("bubble_freeze", ifid_freeze,     0);
            chk("pc_out_hold",   PC_out,          last_pc_out);
            chk("instr_hold",    Instruction_out, last_instr);
        end

        if (pending) begin
            if (branch_taken) begin
                exp_pc  = tgt;
                pending = 1'b0;
            end else if (!hazard_freeze) begin
                exp_pc  = exp_pc + 32'd4;
                pending = 1'b0;
                accepted++;
            end
        end else begin
            if (imem_req && imem_ack && live && !branch_taken) begin
                pending     = 1'b1;
                last_pc_out = exp_pc + 32'd4;
                last_instr  = mem_word(exp_pc);
            end
            if (branch_taken) begin
                exp_pc = tgt;
                live   = 1'b0;
            end
        end
        prev_req  = imem_req;
        prev_ack  = imem_req && imem_ack;
        prev_addr = imem_addr;
    endtask

    initial begin
        logic found;
        accepted = 0;
        model_init();
        quiet_inputs();
        #2 rst = 1'b0;
        @(negedge clk);
        #1 reset_checks("por");
        release_rst();

        repeat (60)  step(0, 0);
        repeat (300) step(0, 30);
        repeat (600) step(10, 20);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0);
            if (imem_req) found = 1'b1;
        end
        chk("mid_req_found", found, 1);
        #2 rst = 1'b0;
        #1 reset_checks("mid_async");
        quiet_inputs();
        @(negedge clk);
        #1 reset_checks("mid_hold");
        release_rst();

        repeat (400) step(15, 25);
        chk("progress", accepted > 100, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
